// File: rtl/audio_pkg.sv
// Shared types and constants for the microphone capture to FFT path.
// Provides the sample-set type and the complex beat packing used by the frame packer.
package audio_pkg;

    localparam int NUM_MICS = 4;
    localparam int SAMPLE_W = 16;
    localparam int FFT_LEN  = 512;

    typedef logic signed [SAMPLE_W-1:0]   sample_t;
    typedef logic [NUM_MICS*SAMPLE_W-1:0] sample_set_t;
    typedef logic [NUM_MICS*32-1:0]       beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } pack_state_e;

    // Each lane is {imag = 0, real = sample}; lane k holds mic k.
    function automatic beat_t pack_complex_beat(input sample_set_t set);
        beat_t beat;
        beat = '0;
        for (int k = 0; k < NUM_MICS; k++) begin
            beat[32*k +: SAMPLE_W] = set[SAMPLE_W*k +: SAMPLE_W];
        end
        return beat;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word: data_out is valid whenever empty_out is low.
// Occupancy counts the head word, so full means DEPTH sets are held in total.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     push_in,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    // A push is refused while full, even if a pop happens in the same cycle.
    assign push_ok = push_in && !full_q;
    assign pop_ok  = pop_in && !empty_q;

    always_comb begin
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        if (count_d == '0) begin
            head_d = '0;
        end else if (push_ok && (count_q == CW'(pop_ok))) begin
            head_d = data_in;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // NOTE: storage has no reset; only pointers and flags define what is valid.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_ok);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    assign data_out  = head_q;
    assign full_out  = full_q;
    assign empty_out = empty_q;
    assign count_out = count_q;

endmodule

// File: rtl/mic_frame_packer.sv
// Packs 4-channel microphone sample sets into complex AXI-Stream beats with tlast every FRAME_LEN beats.
// Framing starts and stops only on frame boundaries; sets arriving while the FIFO is full are counted as drops.
module mic_frame_packer #(
    parameter int NUM_CH     = audio_pkg::NUM_MICS,
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int FRAME_LEN  = audio_pkg::FFT_LEN,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           enable_in,
    input  logic [NUM_CH*SAMPLE_W-1:0]     audio_data_in,
    input  logic                           audio_valid_in,
    output logic                           audio_ready_out,
    output logic [NUM_CH*2*SAMPLE_W-1:0]   m_tdata_out,
    output logic                           m_tvalid_out,
    output logic                           m_tlast_out,
    input  logic                           m_tready_in,
    input  logic                           clr_overflow_in,
    output logic                           overflow_out,
    output logic [15:0]                    drop_count_out,
    output logic [15:0]                    frame_count_out
);

    import audio_pkg::*;

    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    pack_state_e                   state_q;
    logic [CW-1:0]                 in_count_q;
    logic [CW-1:0]                 out_count_q, out_count_d;
    logic [15:0]                   frame_count_q, frame_count_d;
    logic [15:0]                   drop_count_q, drop_count_d;
    logic                          overflow_q, overflow_d;

    logic                          fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [NUM_CH*SAMPLE_W-1:0]    fifo_dout;
    logic                          push, drop, handshake;

    assign audio_ready_out = (state_q == ST_RUN) ? !fifo_full : 1'b1;
    assign push            = (state_q == ST_RUN) && audio_valid_in && !fifo_full;
    assign drop            = (state_q == ST_RUN) && audio_valid_in && fifo_full;
    assign handshake       = m_tvalid_out && m_tready_in;

    sync_fifo #(
        .WIDTH (NUM_CH*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .push_in   (push),
        .data_in   (audio_data_in),
        .pop_in    (handshake),
        .data_out  (fifo_dout),
        .full_out  (fifo_full),
        .empty_out (fifo_empty),
        .count_out (fifo_count)
    );

    // Leaving RUN is only possible on the write that completes a frame, so frames are never cut short.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            in_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_in) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (push) begin
                        in_count_q <= in_count_q + CW'(1);
                        if ((in_count_q == LAST_IDX) && !enable_in) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((fifo_count == '0) && (out_count_q == '0)) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        overflow_d    = overflow_q;
        drop_count_d  = drop_count_q;
        out_count_d   = out_count_q;
        frame_count_d = frame_count_q;

        if (clr_overflow_in) begin
            overflow_d   = 1'b0;
            drop_count_d = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
        end

        if (handshake) begin
            out_count_d = out_count_q + CW'(1);
            if (out_count_q == LAST_IDX) frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overflow_q    <= 1'b0;
            drop_count_q  <= '0;
            out_count_q   <= '0;
            frame_count_q <= '0;
        end else begin
            overflow_q    <= overflow_d;
            drop_count_q  <= drop_count_d;
            out_count_q   <= out_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_tvalid_out    = !fifo_empty;
    assign m_tlast_out     = m_tvalid_out && (out_count_q == LAST_IDX);
    assign m_tdata_out     = pack_complex_beat(fifo_dout);
    assign overflow_out    = overflow_q;
    assign drop_count_out  = drop_count_q;
    assign frame_count_out = frame_count_q;

endmodule
